// File: rtl/game_ctrl.sv
// Purpose: Frogger game-flow sequencer (FSM, lives, score, level, death timer, frog/car control).
// Latency: accepted hit/goal acts on the next cycle; start acts two cycles after assertion; all outputs registered.
// Backpressure: none; inputs are sampled every cycle, and hit/goal are masked while the respawn guard is active.
// Optional: define GAME_CTRL_HISCORE_EN to add the hiscore output and register.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_W      = 8,
  parameter int MAX_LEVEL    = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               start,
  input  logic               hit,
  input  logic               goal,
  output logic [1:0]         game_state,
  output logic               frog_reset,
  output logic               cars_en,
  output logic [2:0]         level,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               frame_tick
`ifdef GAME_CTRL_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  // Encodings double as the frog's state input, so they must not be reordered.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_DYING = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [1:0]         LP_LIVES     = 2'(LIVES);
  localparam logic [7:0]         LP_DEATH     = 8'(DEATH_FRAMES);
  localparam logic [2:0]         LP_MAX_LEVEL = 3'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] LP_SCORE_ONE = SCORE_W'(1);

  // Architectural state
  logic [1:0]         r_state;
  logic [1:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_level;
  logic [7:0]         r_timer;
  logic [1:0]         r_guard;
  logic               r_frog_reset;
  logic               r_cars_en;

  // Input conditioning
  logic               r_vsync_q;
  logic               r_vsync_qq;
  logic               r_frame_tick;
  logic               r_start_q;
  logic               r_start_qq;

  // Next-state values
  logic [1:0]         w_state_nxt;
  logic [1:0]         w_lives_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [2:0]         w_level_nxt;
  logic [7:0]         w_timer_nxt;
  logic               w_frog_reset_nxt;
  logic               w_start_rise;
  logic               w_accept;

  // A start press is one registered rising edge; holding the button does nothing more.
  assign w_start_rise = r_start_q & ~r_start_qq;

  // Collision/goal results are stale while the frog is being returned to its
  // start position, so they are ignored during the reset pulse and the guard window.
  assign w_accept = (r_guard == 2'd0) && !r_frog_reset;

  // Next-state and datapath update decisions for the game FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_level_nxt      = r_level;
    w_timer_nxt      = r_timer;
    w_frog_reset_nxt = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_nxt      = ST_PLAY;
          w_lives_nxt      = LP_LIVES;
          w_score_nxt      = '0;
          w_level_nxt      = 3'd0;
          w_frog_reset_nxt = 1'b1;
        end
      end

      ST_PLAY: begin
        // Goal wins over a same-cycle hit: the frog made it across.
        if (goal && w_accept) begin
          if (r_score != '1) begin
            w_score_nxt = r_score + LP_SCORE_ONE;
          end
          if (r_level < LP_MAX_LEVEL) begin
            w_level_nxt = r_level + 3'd1;
          end
          w_frog_reset_nxt = 1'b1;
        end else if (hit && w_accept) begin
          if (r_lives != 2'd0) begin
            w_lives_nxt = r_lives - 2'd1;
          end
          w_timer_nxt = LP_DEATH;
          w_state_nxt = ST_DYING;
        end
      end

      ST_DYING: begin
        // Leave on the tick that would take the timer to zero.
        if (r_frame_tick) begin
          if (r_timer <= 8'd1) begin
            w_timer_nxt = 8'd0;
            if (r_lives == 2'd0) begin
              w_state_nxt = ST_OVER;
            end else begin
              w_state_nxt      = ST_PLAY;
              w_frog_reset_nxt = 1'b1;
            end
          end else begin
            w_timer_nxt = r_timer - 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register input edges, game state and all outputs; reset takes priority everywhere
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vsync_q    <= 1'b1;
      r_vsync_qq   <= 1'b1;
      r_frame_tick <= 1'b0;
      r_start_q    <= 1'b0;
      r_start_qq   <= 1'b0;
      r_state      <= ST_IDLE;
      r_lives      <= LP_LIVES;
      r_score      <= '0;
      r_level      <= 3'd0;
      r_timer      <= 8'd0;
      r_guard      <= 2'd0;
      r_frog_reset <= 1'b0;
      r_cars_en    <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_vsync_qq   <= r_vsync_q;
      r_frame_tick <= r_vsync_qq & ~r_vsync_q;
      r_start_q    <= start;
      r_start_qq   <= r_start_q;
      r_state      <= w_state_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_level      <= w_level_nxt;
      r_timer      <= w_timer_nxt;
      r_frog_reset <= w_frog_reset_nxt;
      // Cars move only while the frog can: attract mode and active play.
      r_cars_en    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PLAY);
      if (r_frog_reset) begin
        r_guard <= 2'd2;
      end else if (r_guard != 2'd0) begin
        r_guard <= r_guard - 2'd1;
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;

  // Capture the best score on entry to game over; survives new games, not reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hiscore <= '0;
    end else if ((w_state_nxt == ST_OVER) && (r_state != ST_OVER) && (r_score > r_hiscore)) begin
      r_hiscore <= r_score;
    end
  end

  assign hiscore = r_hiscore;
`endif

  assign game_state = r_state;
  assign frog_reset = r_frog_reset;
  assign cars_en    = r_cars_en;
  assign level      = r_level;
  assign lives      = r_lives;
  assign score      = r_score;
  assign frame_tick = r_frame_tick;

  // Invariants: reset and tick outputs are single-cycle pulses; cars stop whenever the frog is frozen.
  a_frog_reset_pulse : assert property (@(posedge clk) disable iff (!reset_n) r_frog_reset |=> !r_frog_reset);
  a_frame_tick_pulse : assert property (@(posedge clk) disable iff (!reset_n) r_frame_tick |=> !r_frame_tick);
  a_cars_stopped     : assert property (@(posedge clk) disable iff (!reset_n) (r_state[1] |-> !r_cars_en));

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected observable-state events,
// a negedge monitor pops one entry per change of {state,lives,score,level,frog_reset,cars_en}.
// Runs with DEATH_FRAMES=4 and a free-running 20-cycle frame.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       goal = 1'b0;
  logic [1:0] game_state;
  logic       frog_reset;
  logic       cars_en;
  logic [2:0] level;
  logic [1:0] lives;
  logic [7:0] score;
  logic       frame_tick;
`ifdef GAME_CTRL_HISCORE_EN
  logic [7:0] hiscore;
`endif

  game_ctrl #(
    .LIVES(3),
    .DEATH_FRAMES(4),
    .SCORE_W(8),
    .MAX_LEVEL(7)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vsync(vsync),
    .start(start),
    .hit(hit),
    .goal(goal),
    .game_state(game_state),
    .frog_reset(frog_reset),
    .cars_en(cars_en),
    .level(level),
    .lives(lives),
    .score(score),
    .frame_tick(frame_tick)
`ifdef GAME_CTRL_HISCORE_EN
    ,
    .hiscore(hiscore)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          ticks_in_dying = 0;
  logic [16:0] q_exp[$];
  string       q_name[$];
  logic [16:0] mon_prev;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic expect_ev(input string nm, input int st, input int lv, input int sc,
                           input int lvl, input int fr, input int ce);
    q_exp.push_back({2'(st), 2'(lv), 8'(sc), 3'(lvl), 1'(fr), 1'(ce)});
    q_name.push_back(nm);
  endtask

  task automatic wait_state(input int st, input int bound, input string nm);
    int k = 0;
    while (32'(game_state) != st && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(game_state), 32'(st));
  endtask

  // Monitor: every change of observable state must match the next queued expectation
  always @(negedge clk) begin
    logic [16:0] cur;
    string       nm;
    logic [16:0] e;
    cur = {game_state, lives, score, level, frog_reset, cars_en};
    if (game_state == 2'b10 && frame_tick) ticks_in_dying++;
    if (cur !== mon_prev) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %h expected none", cur);
      end else begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        check(nm, 32'(cur), 32'(e));
      end
    end
    mon_prev = cur;
  end

  // Frame generator: VSYNC low 2 of every 20 cycles
  initial begin
    forever begin
      repeat (18) @(negedge clk);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
    end
  end

  initial begin
    // Reset state, then attract mode once released
    expect_ev("reset_state", 0, 3, 0, 0, 0, 0);
    expect_ev("idle_cars",   0, 3, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Start: PLAY plus frog_reset two cycles after start
    expect_ev("start_play_fr", 1, 3, 0, 0, 1, 1);
    expect_ev("start_play",    1, 3, 0, 0, 0, 1);
    start = 1'b1;
    @(negedge clk);
    check("start_not_yet", 32'(game_state), 0);
    start = 1'b0;
    @(negedge clk);
    check("start_play_n2", 32'(game_state), 1);
    check("start_frog_reset", 32'(frog_reset), 1);
    repeat (5) @(negedge clk);

    // Single goal
    expect_ev("goal1_fr", 1, 3, 1, 1, 1, 1);
    expect_ev("goal1",    1, 3, 1, 1, 0, 1);
    goal = 1'b1;
    @(negedge clk);
    goal = 1'b0;
    check("goal_score_n1", 32'(score), 1);
    repeat (5) @(negedge clk);

    // Goal held 3 cycles counts once
    expect_ev("goal_hold_fr", 1, 3, 2, 2, 1, 1);
    expect_ev("goal_hold",    1, 3, 2, 2, 0, 1);
    goal = 1'b1;
    repeat (3) @(negedge clk);
    goal = 1'b0;
    check("goal_hold_score", 32'(score), 2);
    repeat (5) @(negedge clk);

    // Seven more goals: level saturates at 7, score reaches 9
    for (int i = 3; i <= 9; i++) begin
      expect_ev("goal_n_fr", 1, 3, i, (i > 7) ? 7 : i, 1, 1);
      expect_ev("goal_n",    1, 3, i, (i > 7) ? 7 : i, 0, 1);
      goal = 1'b1;
      @(negedge clk);
      goal = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("level_sat", 32'(level), 7);
    check("score_9", 32'(score), 9);

    // Death 1: hit/goal inside DYING are ignored; respawn after 4 ticks
    expect_ev("death1",       2, 2, 9, 7, 0, 0);
    expect_ev("respawn1_fr",  1, 2, 9, 7, 1, 1);
    expect_ev("respawn1",     1, 2, 9, 7, 0, 1);
    ticks_in_dying = 0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    check("dying_cars_en", 32'(cars_en), 0);
    repeat (3) @(negedge clk);
    hit = 1'b1;
    goal = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    goal = 1'b0;
    wait_state(1, 200, "respawn1_state");
    check("dying_ticks1", 32'(ticks_in_dying), 4);
    repeat (5) @(negedge clk);

    // Simultaneous hit and goal: goal wins
    expect_ev("sim_fr", 1, 2, 10, 7, 1, 1);
    expect_ev("sim",    1, 2, 10, 7, 0, 1);
    hit = 1'b1;
    goal = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    goal = 1'b0;
    check("sim_lives", 32'(lives), 2);
    repeat (5) @(negedge clk);

    // Death 2
    expect_ev("death2",      2, 1, 10, 7, 0, 0);
    expect_ev("respawn2_fr", 1, 1, 10, 7, 1, 1);
    expect_ev("respawn2",    1, 1, 10, 7, 0, 1);
    ticks_in_dying = 0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    wait_state(1, 200, "respawn2_state");
    check("dying_ticks2", 32'(ticks_in_dying), 4);
    repeat (5) @(negedge clk);

    // Death 3: game over, no frog_reset
    expect_ev("death3", 2, 0, 10, 7, 0, 0);
    expect_ev("over",   3, 0, 10, 7, 0, 0);
    ticks_in_dying = 0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    wait_state(3, 200, "over_state");
    check("dying_ticks3", 32'(ticks_in_dying), 4);
    check("over_lives", 32'(lives), 0);
    repeat (5) @(negedge clk);
    check("over_cars_en", 32'(cars_en), 0);

    // Restart from OVER
    expect_ev("restart_fr", 1, 3, 0, 0, 1, 1);
    expect_ev("restart",    1, 3, 0, 0, 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("restart_state", 32'(game_state), 1);
`ifdef GAME_CTRL_HISCORE_EN
    check("hiscore", 32'(hiscore), 10);
`endif
    repeat (5) @(negedge clk);

    // Reset while DYING with timer=2: back to reset values, no frog_reset
    expect_ev("death4",      2, 2, 0, 0, 0, 0);
    expect_ev("mid_reset",   0, 3, 0, 0, 0, 0);
    expect_ev("mid_idle",    0, 3, 0, 0, 0, 1);
    ticks_in_dying = 0;
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    for (int k = 0; k < 200 && ticks_in_dying < 2; k++) @(negedge clk);
    check("dying_two_ticks", 32'(ticks_in_dying), 2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_reset_state", 32'(game_state), 0);
    check("mid_reset_lives", 32'(lives), 3);
    repeat (3) @(negedge clk);

    // Start held 100 cycles in IDLE: exactly one transition
    expect_ev("held_fr", 1, 3, 0, 0, 1, 1);
    expect_ev("held",    1, 3, 0, 0, 0, 1);
    start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_state", 32'(game_state), 1);
    check("queue_drained", 32'(q_exp.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
